// File: rtl/mlp_sched_pkg.sv
// Shared types and constants for the MLP frame scheduler.
//   sched_state_t : frame sequencing states
//   IDX_W         : width of the MLP inference index
//   TIMEOUT_IDX   : index reported when a frame is aborted by timeout
//   clog2_min1    : $clog2 clamped to at least 1 bit (source ID width)
package mlp_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        STREAM,
        WAIT,
        RESULT
    } sched_state_t;

    localparam int         IDX_W       = 4;
    localparam logic [3:0] TIMEOUT_IDX = 4'hF;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mlp_req_arbiter.sv
// Combinational grant selection among the pixel sources.
// Macro MLP_SCHED_RR_ARB_EN selects round-robin (search starts after
// last_grant); otherwise fixed priority with the lowest index winning.
// Ports:
//   req_valid  in  per-source request
//   last_grant in  previous grant (round-robin build only)
//   grant_idx  out selected source index (0 when nothing is requesting)
//   any_valid  out at least one source is requesting
module mlp_req_arbiter
    import mlp_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int SRC_W = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
`ifdef MLP_SCHED_RR_ARB_EN
    input  logic [SRC_W-1:0] last_grant,
`endif
    output logic [SRC_W-1:0] grant_idx,
    output logic             any_valid
);

`ifdef MLP_SCHED_RR_ARB_EN
    int   cand;
    logic found;

    // Walk the sources starting one past the previous winner; the first
    // requester found wins, so each source waits at most N_REQ-1 frames.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_grant) + k) % N_REQ;
            if (!found && req_valid[cand]) begin
                grant_idx = SRC_W'(cand);
                found     = 1'b1;
            end
        end
    end
`else
    // Scan from the top down so the lowest requesting index is written last.
    always_comb begin
        grant_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) grant_idx = SRC_W'(i);
        end
    end
`endif

    assign any_valid = |req_valid;

endmodule

// File: rtl/mlp_frame_scheduler.sv
// Shares one MNIST MLP inference core between N_REQ pixel sources.
// One source is granted per frame, N_PIXELS pixels are passed through to the
// core, and the core's result (or a timeout marker) is returned tagged with
// the source ID. Macro MLP_SCHED_RR_ARB_EN enables round-robin arbitration.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/req_pixel  per-source pixel stream (source i at [i*PIX_W +: PIX_W])
//   req_ready            per-source ready, only the granted bit can be high
//   mlp_input_en/pixel   pixel strobe and data to the MLP
//   mlp_output_en/index  MLP result strobe and digit
//   res_valid            one-cycle result pulse
//   res_index/src/timeout result digit (4'hF on timeout), source, abort flag
//   busy                 high whenever not idle
module mlp_frame_scheduler
    import mlp_sched_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int N_PIXELS       = 784,
    parameter int PIX_W          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*PIX_W-1:0]        req_pixel,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          mlp_input_en,
    output logic [PIX_W-1:0]              mlp_pixel,
    input  logic                          mlp_output_en,
    input  logic [IDX_W-1:0]              mlp_inference_index,
    output logic                          res_valid,
    output logic [IDX_W-1:0]              res_index,
    output logic [clog2_min1(N_REQ)-1:0]  res_src,
    output logic                          res_timeout,
    output logic                          busy
);

    localparam int SRC_W  = clog2_min1(N_REQ);
    localparam int PCNT_W = $clog2(N_PIXELS + 1);
    localparam int TCNT_W = clog2_min1(TIMEOUT_CYCLES);

    sched_state_t      state, state_next;
    logic [SRC_W-1:0]  grant;
    logic [SRC_W-1:0]  arb_idx;
    logic              arb_any;
    logic [PCNT_W-1:0] pix_cnt;
    logic [TCNT_W-1:0] tmo_cnt;
    logic [PIX_W-1:0]  pix_arr [N_REQ];
    logic              xfer;
    logic              last_pix;
    logic              tmo_hit;

`ifdef MLP_SCHED_RR_ARB_EN
    logic [SRC_W-1:0]  last_grant;

    // Resets to the highest index so source 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!rst_n)                last_grant <= SRC_W'(N_REQ - 1);
        else if (state == RESULT)  last_grant <= grant;
    end
`endif

    mlp_req_arbiter #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_arb (
        .req_valid  (req_valid),
`ifdef MLP_SCHED_RR_ARB_EN
        .last_grant (last_grant),
`endif
        .grant_idx  (arb_idx),
        .any_valid  (arb_any)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) pix_arr[i] = req_pixel[i*PIX_W +: PIX_W];
    end

    // The grant is registered in ARB, so the pixel path is a pure mux.
    assign xfer     = (state == STREAM) && req_valid[grant];
    assign last_pix = xfer && (pix_cnt == PCNT_W'(N_PIXELS - 1));
    assign tmo_hit  = (state == WAIT) && (tmo_cnt == TCNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next   = state;
        req_ready    = '0;
        mlp_input_en = xfer;
        mlp_pixel    = xfer ? pix_arr[grant] : '0;
        res_valid    = (state == RESULT);
        busy         = (state != IDLE);
        if (state == STREAM) req_ready[grant] = 1'b1;

        unique case (state)
            IDLE:    if (arb_any) state_next = ARB;
            ARB:     state_next = arb_any ? STREAM : IDLE;
            STREAM:  if (last_pix) state_next = WAIT;
            // output_en wins over a simultaneous timeout expiry.
            WAIT:    if (mlp_output_en || tmo_hit) state_next = RESULT;
            RESULT:  state_next = arb_any ? ARB : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            pix_cnt     <= '0;
            tmo_cnt     <= '0;
            res_index   <= '0;
            res_src     <= '0;
            res_timeout <= 1'b0;
        end else begin
            state <= state_next;

            if (state == ARB) begin
                grant   <= arb_idx;
                pix_cnt <= '0;
            end else if (last_pix) begin
                pix_cnt <= '0;
            end else if (xfer) begin
                pix_cnt <= pix_cnt + 1'b1;
            end

            // Counts cycles spent in WAIT; cleared everywhere else so it
            // starts at 0 on each entry.
            tmo_cnt <= (state == WAIT) ? tmo_cnt + 1'b1 : '0;

            // Results are captured on the WAIT exit edge so they appear
            // together with res_valid and hold until the next result.
            if (state == WAIT) begin
                if (mlp_output_en) begin
                    res_index   <= mlp_inference_index;
                    res_src     <= grant;
                    res_timeout <= 1'b0;
                end else if (tmo_hit) begin
                    res_index   <= TIMEOUT_IDX;
                    res_src     <= grant;
                    res_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mlp_frame_scheduler.sv
module tb_mlp_frame_scheduler;
    import mlp_sched_pkg::*;

    localparam int N_REQ          = 2;
    localparam int N_PIXELS       = 784;
    localparam int PIX_W          = 8;
    localparam int TIMEOUT_CYCLES = 4096;
    localparam int SRC_W          = clog2_min1(N_REQ);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*PIX_W-1:0] req_pixel;
    logic [N_REQ-1:0]       req_ready;
    logic                   mlp_input_en;
    logic [PIX_W-1:0]       mlp_pixel;
    logic                   mlp_output_en;
    logic [IDX_W-1:0]       mlp_inference_index;
    logic                   res_valid;
    logic [IDX_W-1:0]       res_index;
    logic [SRC_W-1:0]       res_src;
    logic                   res_timeout;
    logic                   busy;

    always #5 clk = ~clk;

    mlp_frame_scheduler #(
        .N_REQ(N_REQ), .N_PIXELS(N_PIXELS), .PIX_W(PIX_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_pixel(req_pixel), .req_ready(req_ready),
        .mlp_input_en(mlp_input_en), .mlp_pixel(mlp_pixel),
        .mlp_output_en(mlp_output_en), .mlp_inference_index(mlp_inference_index),
        .res_valid(res_valid), .res_index(res_index), .res_src(res_src),
        .res_timeout(res_timeout), .busy(busy)
    );

    typedef struct {
        int idx;
        int src;
        int tmo;
        int lat;
    } res_exp_t;

    // Scoreboard
    logic [PIX_W-1:0] pix_q[$];
    res_exp_t         res_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Source model
    logic [PIX_W-1:0] src_data [N_REQ][N_PIXELS];
    int               pos  [N_REQ];
    bit               fire [N_REQ];
    logic [N_REQ-1:0] active = '0;
    int               stall_mode = 0;
    int               drv_cyc = 0;

    // Reference arbitration model and expectations
    int exp_grant  = 0;
    int model_last = N_REQ - 1;
    int frame_no   = 0;

    // MLP model
    int mlp_delay  = -1;
    int mlp_idx    = 0;
    int mlp_spur   = -1;
    bit spur_done  = 1'b1;
    int mlp_in_cnt = 0;
    int mlp_since  = -1;

    // Monitor state
    int cyc = 0;
    int last_pix_cyc = 0;
    int held_idx = 0, held_src = 0, held_to = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int hold_word(input int i, input int s, input int t);
        return i * 256 + s * 2 + t;
    endfunction

    function automatic bit stalled();
        case (stall_mode)
            1:       return (drv_cyc % 3) == 0;
            2:       return $urandom_range(3) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Whichever requester the arbitration rule picks for this request set.
    function automatic int model_grant(input logic [N_REQ-1:0] mask);
`ifdef MLP_SCHED_RR_ARB_EN
        for (int k = 1; k <= N_REQ; k++)
            if (mask[(model_last + k) % N_REQ]) return (model_last + k) % N_REQ;
`else
        for (int k = 0; k < N_REQ; k++)
            if (mask[k]) return k;
`endif
        return 0;
    endfunction

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    // Pixel sources: drive on negedge, note handshakes just after.
    initial begin
        bit v;
        req_valid = '0;
        req_pixel = '0;
        forever begin
            @(negedge clk);
            drv_cyc++;
            for (int i = 0; i < N_REQ; i++) begin
                if (fire[i]) pos[i]++;
                v = active[i] && (pos[i] < N_PIXELS) && !(pos[i] > 0 && stalled());
                req_valid[i] = v;
                if (v) req_pixel[i*PIX_W +: PIX_W] = src_data[i][pos[i]];
                else   req_pixel[i*PIX_W +: PIX_W] = PIX_W'($urandom);
            end
            #1;
            for (int i = 0; i < N_REQ; i++) fire[i] = req_valid[i] & req_ready[i];
        end
    end

    // MLP core model: answers mlp_delay cycles after its N_PIXELS-th input.
    initial begin
        mlp_output_en       = 1'b0;
        mlp_inference_index = '0;
        forever begin
            @(negedge clk);
            mlp_output_en       = 1'b0;
            mlp_inference_index = IDX_W'($urandom);
            if (mlp_since >= 0) mlp_since++;
            if (mlp_since >= 0 && mlp_since == mlp_delay) begin
                mlp_output_en       = 1'b1;
                mlp_inference_index = IDX_W'(mlp_idx);
                mlp_since           = -1;
            end else if (!spur_done && mlp_in_cnt == mlp_spur) begin
                mlp_output_en       = 1'b1;
                mlp_inference_index = 4'd9;
                spur_done           = 1'b1;
            end
            #2;
            if (mlp_input_en) begin
                mlp_in_cnt++;
                if (mlp_in_cnt == N_PIXELS) mlp_since = 0;
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard queues.
    initial begin
        logic [PIX_W-1:0] e;
        res_exp_t r;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            check("ready_only_granted", 32'(req_ready & ~(N_REQ'(1) << exp_grant)), 0);
            if (mlp_input_en) begin
                check("input_en_without_valid", req_valid[exp_grant], 1'b1);
                if (pix_q.size() == 0) begin
                    check("input_en_unexpected", mlp_input_en, 1'b0);
                end else begin
                    e = pix_q.pop_front();
                    check("pixel", mlp_pixel, e);
                    if (pix_q.size() == 0) last_pix_cyc = cyc;
                end
            end
            if (res_valid) begin
                if (res_q.size() == 0) begin
                    check("res_valid_unexpected", res_valid, 1'b0);
                end else begin
                    r = res_q.pop_front();
                    check("res_index", res_index, r.idx);
                    check("res_src", res_src, r.src);
                    check("res_timeout", res_timeout, r.tmo);
                    check("res_latency", cyc - last_pix_cyc, r.lat);
                    held_idx = r.idx;
                    held_src = r.src;
                    held_to  = r.tmo;
                end
            end else begin
                check("res_hold", hold_word(int'(res_index), int'(res_src), int'(res_timeout)),
                      hold_word(held_idx, held_src, held_to));
            end
        end
    end

    // Queue one frame: predicted grant, its pixel stream and its result.
    // idx < 0 means the MLP answers with (source + 3); delay < 0 means never.
    task automatic start_frame(input logic [N_REQ-1:0] mask, input int stall, input int delay,
                               input int idx, input int spur, input bit ramp, output int g);
        res_exp_t r;
        g = model_grant(mask);
        frame_no++;
        $display("frame %0d: mask %b, predicted grant %0d (previous %0d)", frame_no, mask, g, model_last);
        for (int i = 0; i < N_REQ; i++)
            for (int p = 0; p < N_PIXELS; p++)
                src_data[i][p] = ramp ? PIX_W'(p) : PIX_W'($urandom);
        for (int p = 0; p < N_PIXELS; p++) pix_q.push_back(src_data[g][p]);
        mlp_idx = (idx < 0) ? g + 3 : idx;
        if (delay >= 1 && delay <= TIMEOUT_CYCLES) begin
            r.idx = mlp_idx; r.tmo = 0; r.lat = delay + 1;
        end else begin
            r.idx = 4'hF; r.tmo = 1; r.lat = TIMEOUT_CYCLES + 1;
        end
        r.src = g;
        res_q.push_back(r);
        exp_grant  = g;
        model_last = g;
        mlp_delay  = delay;
        mlp_spur   = spur;
        spur_done  = (spur < 0);
        mlp_in_cnt = 0;
        mlp_since  = -1;
        stall_mode = stall;
        for (int i = 0; i < N_REQ; i++) begin
            pos[i]  = 0;
            fire[i] = 1'b0;
        end
        active = mask;
    endtask

    task automatic finish_frame(input int g);
        int budget;
        budget = 0;
        while (pos[g] < N_PIXELS && budget < 8 * N_PIXELS) begin
            step();
            budget++;
        end
        check("stream_complete", pos[g], N_PIXELS);
        active = '0;
        budget = 0;
        while (res_q.size() != 0 && budget < TIMEOUT_CYCLES + 200) begin
            step();
            budget++;
        end
        check("result_delivered", res_q.size(), 0);
        res_q.delete();
        pix_q.delete();
        repeat (3) step();
        check("idle_after_frame", busy, 1'b0);
    endtask

    task automatic run_frame(input logic [N_REQ-1:0] mask, input int stall, input int delay,
                             input int idx, input int spur, input bit ramp);
        int g;
        start_frame(mask, stall, delay, idx, spur, ramp, g);
        finish_frame(g);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_mlp_input_en"}, mlp_input_en, 0);
        check({tag, "_mlp_pixel"}, mlp_pixel, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_index"}, res_index, 0);
        check({tag, "_res_src"}, res_src, 0);
        check({tag, "_res_timeout"}, res_timeout, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int g;
        int budget;
        logic [N_REQ-1:0] mask;

        rst_n = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Single source, ramp data, result 10 cycles after the last pixel.
        run_frame(2'b01, 0, 10, 7, -1, 1'b1);
        // Source 1 alone with a stall every third cycle.
        run_frame(2'b10, 1, 5, 2, -1, 1'b0);
        // Contention: both sources request each frame, index = source + 3.
        repeat (4) run_frame(2'b11, 0, 8, -1, -1, 1'b0);
        // Timeout, then a normal frame.
        run_frame(2'b01, 0, -1, 0, -1, 1'b0);
        run_frame(2'b10, 0, 3, 5, -1, 1'b0);
        // Spurious output_en mid-stream is ignored.
        run_frame(2'b11, 2, 6, 1, 100, 1'b0);
        // output_en on the final timeout cycle wins.
        run_frame(2'b01, 0, TIMEOUT_CYCLES, 4, -1, 1'b0);

        // Reset in the middle of a stream drops the frame silently.
        start_frame(2'b01, 0, 10, 7, -1, 1'b0, g);
        budget = 0;
        while (pos[0] < 400 && budget < 4 * N_PIXELS) begin
            step();
            budget++;
        end
        check("reached_pixel_400", pos[0] >= 400, 1'b1);
        rst_n      = 1'b0;
        active     = '0;
        mlp_delay  = -1;
        mlp_since  = -1;
        mlp_in_cnt = 0;
        held_idx   = 0;
        held_src   = 0;
        held_to    = 0;
        pix_q.delete();
        res_q.delete();
        step();
        check_all_zero("midreset");
        model_last = N_REQ - 1;
        rst_n = 1'b1;
        step();
        step();
        check("idle_after_midreset", busy, 1'b0);
        run_frame(2'b01, 0, 12, 6, -1, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 4; f++) begin
            mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            run_frame(mask, $urandom_range(2), $urandom_range(1, 60), $urandom_range(9),
                      ($urandom_range(1) == 1) ? $urandom_range(1, N_PIXELS - 1) : -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
